// File: rtl/lighthouse_sweep_sequencer.sv
// Lighthouse photodiode pulse sequencer: times envelope pulses, decodes sync codes,
// arms a sweep window on non-skip syncs and reports sweep-hit centre relative to the arming sync.
module lighthouse_sweep_sequencer #(
    parameter int WIDTH        = 20,
    parameter int SYNC_BASE    = 3000,
    parameter int SYNC_STEP    = 500,
    parameter int SWEEP_MAX    = 960,
    parameter int PAIR_GAP     = 48000,
    parameter int SWEEP_WINDOW = 400000
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             envelope_i,
    output logic             sync_valid_o,
    output logic [2:0]       sync_code_o,
    output logic             sync_station_o,
    output logic             sweep_valid_o,
    output logic [WIDTH-1:0] sweep_time_o,
    output logic             sweep_axis_o,
    output logic             sweep_station_o,
    output logic             timeout_o,
    output logic             error_o
);
    localparam int SYNC_MAX = SYNC_BASE + 7 * SYNC_STEP + SYNC_STEP / 2;
    localparam logic [WIDTH-1:0] SYNC_MAX_W  = WIDTH'(SYNC_MAX);
    localparam logic [WIDTH-1:0] SWEEP_MAX_W = WIDTH'(SWEEP_MAX);
    localparam logic [WIDTH-1:0] PAIR_GAP_W  = WIDTH'(PAIR_GAP);
    localparam logic [WIDTH-1:0] WINDOW_W    = WIDTH'(SWEEP_WINDOW);

    typedef enum logic {IDLE, ARMED} state_t;

    logic             env_s1_q, env_s2_q, env_prev_q;
    logic [2:0]       prime_q;
    logic             rise_q, fall_q;
    logic [WIDTH-1:0] t_q, t_rise_q, t_rise_d, ref_q, ref_d, last_sync_q, last_sync_d;
    logic             seen_rise_q, seen_rise_d, long_q, long_d, has_sync_q, has_sync_d;
    logic             arm_axis_q, arm_axis_d, arm_station_q, arm_station_d;
    state_t           state_q, state_d;

    logic             sync_valid_q, sync_valid_d, sync_station_q, sync_station_d;
    logic [2:0]       sync_code_q, sync_code_d;
    logic             sweep_valid_q, sweep_valid_d, sweep_axis_q, sweep_axis_d;
    logic             sweep_station_q, sweep_station_d, timeout_q, timeout_d, error_q, error_d;
    logic [WIDTH-1:0] sweep_time_q, sweep_time_d;

    logic [WIDTH-1:0] width, elapsed;
    logic             classify, is_sweep, sync_hit, err_hit, ladder_hit, station_c;
    logic [2:0]       code_c;

    always_comb begin
        width    = t_q - t_rise_q;
        elapsed  = t_q - ref_q;
        classify = fall_q & seen_rise_q;

        ladder_hit = 1'b0;
        code_c     = 3'd0;
        for (int n = 0; n < 8; n++) begin
            if (width >= WIDTH'(SYNC_BASE + n * SYNC_STEP - SYNC_STEP / 2) &&
                width <  WIDTH'(SYNC_BASE + n * SYNC_STEP + SYNC_STEP / 2)) begin
                ladder_hit = 1'b1;
                code_c     = 3'(n);
            end
        end

        is_sweep  = classify & ~long_q & (width < SWEEP_MAX_W);
        sync_hit  = classify & ~long_q & ~is_sweep & ladder_hit;
        err_hit   = classify & ~is_sweep & ~sync_hit;
        station_c = has_sync_q & ((t_rise_q - last_sync_q) < PAIR_GAP_W);

        t_rise_d        = t_rise_q;
        seen_rise_d     = seen_rise_q;
        long_d          = long_q;
        ref_d           = ref_q;
        last_sync_d     = last_sync_q;
        has_sync_d      = has_sync_q;
        arm_axis_d      = arm_axis_q;
        arm_station_d   = arm_station_q;
        state_d         = state_q;
        sync_valid_d    = 1'b0;
        sync_code_d     = sync_code_q;
        sync_station_d  = sync_station_q;
        sweep_valid_d   = 1'b0;
        sweep_time_d    = sweep_time_q;
        sweep_axis_d    = sweep_axis_q;
        sweep_station_d = sweep_station_q;
        timeout_d       = 1'b0;
        error_d         = 1'b0;

        if (rise_q) begin
            t_rise_d    = t_q;
            seen_rise_d = 1'b1;
            long_d      = 1'b0;
        end else if (fall_q) begin
            seen_rise_d = 1'b0;
            long_d      = 1'b0;
        end else if (seen_rise_q && width > SYNC_MAX_W) begin
            // Sticky so a very long pulse stays an error even after the width wraps.
            long_d = 1'b1;
        end

        if (sync_hit) begin
            sync_valid_d   = 1'b1;
            sync_code_d    = code_c;
            sync_station_d = station_c;
            last_sync_d    = t_rise_q;
            has_sync_d     = 1'b1;
            if (!code_c[2]) begin
                ref_d         = t_rise_q;
                arm_axis_d    = code_c[0];
                arm_station_d = station_c;
                state_d       = ARMED;
            end
        end else if (is_sweep) begin
            if (state_q == ARMED) begin
                sweep_valid_d   = 1'b1;
                sweep_time_d    = t_rise_q + (width >> 1) - ref_q;
                sweep_axis_d    = arm_axis_q;
                sweep_station_d = arm_station_q;
                state_d         = IDLE;
            end
        end else if (err_hit) begin
            error_d = 1'b1;
        end else if (state_q == ARMED && elapsed > WINDOW_W) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            env_s1_q        <= 1'b0;
            env_s2_q        <= 1'b0;
            env_prev_q      <= 1'b0;
            prime_q         <= 3'b000;
            rise_q          <= 1'b0;
            fall_q          <= 1'b0;
            t_q             <= '0;
            t_rise_q        <= '0;
            seen_rise_q     <= 1'b0;
            long_q          <= 1'b0;
            ref_q           <= '0;
            last_sync_q     <= '0;
            has_sync_q      <= 1'b0;
            arm_axis_q      <= 1'b0;
            arm_station_q   <= 1'b0;
            state_q         <= IDLE;
            sync_valid_q    <= 1'b0;
            sync_code_q     <= 3'd0;
            sync_station_q  <= 1'b0;
            sweep_valid_q   <= 1'b0;
            sweep_time_q    <= '0;
            sweep_axis_q    <= 1'b0;
            sweep_station_q <= 1'b0;
            timeout_q       <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            env_s1_q        <= envelope_i;
            env_s2_q        <= env_s1_q;
            env_prev_q      <= env_s2_q;
            // Edges are ignored until the synchronizer and edge register hold real samples,
            // so a pulse already high at reset release never produces a rise.
            prime_q         <= {prime_q[1:0], 1'b1};
            rise_q          <= prime_q[2] & env_s2_q & ~env_prev_q;
            fall_q          <= prime_q[2] & ~env_s2_q & env_prev_q;
            t_q             <= t_q + 1'b1;
            t_rise_q        <= t_rise_d;
            seen_rise_q     <= seen_rise_d;
            long_q          <= long_d;
            ref_q           <= ref_d;
            last_sync_q     <= last_sync_d;
            has_sync_q      <= has_sync_d;
            arm_axis_q      <= arm_axis_d;
            arm_station_q   <= arm_station_d;
            state_q         <= state_d;
            sync_valid_q    <= sync_valid_d;
            sync_code_q     <= sync_code_d;
            sync_station_q  <= sync_station_d;
            sweep_valid_q   <= sweep_valid_d;
            sweep_time_q    <= sweep_time_d;
            sweep_axis_q    <= sweep_axis_d;
            sweep_station_q <= sweep_station_d;
            timeout_q       <= timeout_d;
            error_q         <= error_d;
        end
    end

    assign sync_valid_o    = sync_valid_q;
    assign sync_code_o     = sync_code_q;
    assign sync_station_o  = sync_station_q;
    assign sweep_valid_o   = sweep_valid_q;
    assign sweep_time_o    = sweep_time_q;
    assign sweep_axis_o    = sweep_axis_q;
    assign sweep_station_o = sweep_station_q;
    assign timeout_o       = timeout_q;
    assign error_o         = error_q;
endmodule

// File: tb/tb_lighthouse_sweep_sequencer.sv
// Bench for lighthouse_sweep_sequencer at scaled-down timing parameters so that long windows
// and counter wrap stay short; expected strobes come from a pulse-level model of the decode rules.
module tb_lighthouse_sweep_sequencer;
    localparam int TW      = 12;
    localparam int BASE    = 300;
    localparam int STEP    = 50;
    localparam int SMAX    = 96;
    localparam int PGAP    = 1200;
    localparam int WIN     = 2000;
    localparam int MASK    = (1 << TW) - 1;
    localparam int SYNCMAX = BASE + 7 * STEP + STEP / 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          env = 1'b0;
    logic          sync_valid, sync_station, sweep_valid, sweep_axis, sweep_station, timeout, error;
    logic [2:0]    sync_code;
    logic [TW-1:0] sweep_time;

    lighthouse_sweep_sequencer #(
        .WIDTH(TW), .SYNC_BASE(BASE), .SYNC_STEP(STEP), .SWEEP_MAX(SMAX),
        .PAIR_GAP(PGAP), .SWEEP_WINDOW(WIN)
    ) dut (
        .clk_i(clk), .reset_i(rst), .envelope_i(env),
        .sync_valid_o(sync_valid), .sync_code_o(sync_code), .sync_station_o(sync_station),
        .sweep_valid_o(sweep_valid), .sweep_time_o(sweep_time), .sweep_axis_o(sweep_axis),
        .sweep_station_o(sweep_station), .timeout_o(timeout), .error_o(error)
    );

    always #5 clk = ~clk;

    // Ticks since reset release; equals the design's free-running counter.
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // kind one-hot: [0] sync, [1] sweep, [2] timeout, [3] error
    typedef struct packed {
        logic [3:0]    kind;
        logic [2:0]    code;
        logic          station;
        logic [TW-1:0] tm;
        logic          axis;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    bit m_armed, m_has, m_axis, m_st;
    int m_ref, m_last;

    task automatic push(input logic [3:0] k, input int code, input bit st, input int tm, input bit ax);
        exp_t e;
        int   c;
        int   t;
        c         = code;
        t         = tm & MASK;
        e.kind    = k;
        e.code    = c[2:0];
        e.station = st;
        e.tm      = t[TW-1:0];
        e.axis    = ax;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_armed = 0;
        m_has   = 0;
    endtask

    task automatic model_fall(input int cr, input int w);
        int n;
        bit st;
        if (w < SMAX) begin
            if (m_armed) begin
                push(4'b0010, 0, m_st, (cr - m_ref) + w / 2, m_axis);
                m_armed = 0;
            end
        end else if (w >= BASE - STEP / 2 && w < SYNCMAX) begin
            n      = (w - (BASE - STEP / 2)) / STEP;
            st     = m_has && (((cr - m_last) & MASK) < PGAP);
            m_has  = 1;
            m_last = cr;
            push(4'b0001, n, st, 0, 1'b0);
            if (n < 4) begin
                m_armed = 1;
                m_ref   = cr;
                m_axis  = n[0];
                m_st    = st;
            end
        end else begin
            push(4'b1000, 0, 1'b0, 0, 1'b0);
        end
    endtask

    // Low for 'low' ticks then high for 'high' ticks; called on a falling clock edge.
    task automatic pulse(input int low, input int high);
        int cr;
        if (m_armed && (cyc + low + high) - m_ref > WIN + 1) begin
            push(4'b0100, 0, 1'b0, 0, 1'b0);
            m_armed = 0;
        end
        repeat (low) @(negedge clk);
        env = 1'b1;
        cr  = cyc;
        repeat (high) @(negedge clk);
        env = 1'b0;
        model_fall(cr, high);
    endtask

    task automatic drain(input int bound);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expected strobes still pending after %0d cycles, required 0",
                     exp_q.size(), bound);
            exp_q.delete();
        end
    endtask

    task automatic settle();
        if (m_armed) begin
            push(4'b0100, 0, 1'b0, 0, 1'b0);
            m_armed = 0;
        end
        drain(WIN + 100);
        repeat (8) @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        compared++;
        if ({sync_valid, sync_code, sync_station, sweep_valid, sweep_time, sweep_axis,
             sweep_station, timeout, error} != '0) begin
            mismatched++;
            $display("FAIL %s: outputs sv=%b code=%b st=%b wv=%b time=%0d ax=%b wst=%b to=%b err=%b, required all 0",
                     name, sync_valid, sync_code, sync_station, sweep_valid, sweep_time,
                     sweep_axis, sweep_station, timeout, error);
        end
    endtask

    task automatic hit_reset(input string name);
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero(name);
        rst = 1'b0;
    endtask

    exp_t       e;
    logic [3:0] act;
    bit         bad;
    always @(negedge clk) begin
        act = {error, timeout, sweep_valid, sync_valid};
        if (act != 4'b0000) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_strobe: got kind=%b code=%0d time=%0d, required no strobe",
                         act, sync_code, sweep_time);
            end else begin
                e   = exp_q.pop_front();
                bad = (act != e.kind);
                if (e.kind[0]) bad = bad || (sync_code != e.code) || (sync_station != e.station);
                if (e.kind[1]) bad = bad || (sweep_time != e.tm) || (sweep_axis != e.axis) ||
                                     (sweep_station != e.station);
                if (bad) begin
                    mismatched++;
                    $display("FAIL strobe: got kind=%b code=%0d st=%0d time=%0d ax=%0d wst=%0d, required kind=%b code=%0d st=%0d time=%0d ax=%0d",
                             act, sync_code, sync_station, sweep_time, sweep_axis, sweep_station,
                             e.kind, e.code, e.station, e.tm, e.axis);
                end
            end
        end
    end

    int blist[9] = '{95, 96, 274, 275, 324, 325, 674, 675, 676};

    initial begin
        int low;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // code 0 sync then sweep 1000 ticks after sync rise
        pulse(20, 300);
        pulse(700, 20);
        settle();

        // skip sync then second sync of pair, sweep against the second
        repeat (PGAP + 10) @(negedge clk);
        pulse(20, 500);
        pulse(200, 350);
        pulse(1150, 10);
        settle();

        // width boundaries; errors must leave the arming intact
        pulse(20, 275);
        pulse(20, 325);
        pulse(20, 96);
        pulse(20, 200);
        pulse(20, 700);
        pulse(20, 95);
        pulse(20, 50);
        settle();

        // timeout: fall exactly at window+1 wins, one tick later the window expires first
        pulse(20, 300);
        pulse(WIN + 1 - 320, 20);
        pulse(20, 300);
        pulse(WIN + 2 - 320, 20);
        pulse(20, 300);
        pulse(WIN + 50, 20);
        settle();

        // reset with envelope high, then drop it
        env = 1'b1;
        repeat (10) @(negedge clk);
        hit_reset("reset_midpulse");
        repeat (20) @(negedge clk);
        env = 1'b0;
        repeat (20) @(negedge clk);

        // reset while armed, later sweep ignored
        pulse(20, 300);
        drain(50);
        hit_reset("reset_armed");
        repeat (10) @(negedge clk);
        pulse(20, 20);
        settle();

        // arm 100 ticks before the counter wraps
        low = (MASK + 1 - 103 - cyc) & MASK;
        if (low < 2) low += MASK + 1;
        pulse(low, 300);
        pulse(100, 20);
        settle();

        for (int i = 0; i < 60; i++) begin
            int cat;
            int w;
            int n;
            cat = $urandom_range(0, 9);
            if (cat <= 3) begin
                n = $urandom_range(0, 7);
                w = BASE + n * STEP - STEP / 2 + $urandom_range(0, STEP - 1);
            end else if (cat <= 6) begin
                w = $urandom_range(2, SMAX - 1);
            end else if (cat == 7) begin
                if ($urandom_range(0, 1) == 1) w = $urandom_range(SMAX, BASE - STEP / 2 - 1);
                else                           w = $urandom_range(SYNCMAX + 1, 900);
            end else begin
                w = blist[$urandom_range(0, 8)];
            end
            if ($urandom_range(0, 7) == 0) low = $urandom_range(1800, 2200);
            else                           low = $urandom_range(2, 700);
            pulse(low, w);
        end
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/lighthouse_sweep_sequencer.md
# lighthouse_sweep_sequencer

Sequences pulse timing for one Lighthouse photodiode channel: measures every envelope pulse against a free-running tick counter, classifies it as sync or sweep, and decodes sync codes (skip/data/axis). It arms a sweep window on each non-skip sync and reports the sweep-hit time relative to that sync. It sits between the photodiode envelope input and the pose solver, one instance per sensor.

## Interface
- WIDTH, 20: bits of tick counter, timestamps, widths; 2^WIDTH must exceed SWEEP_WINDOW + SYNC_MAX.
- SYNC_BASE, 3000: ticks for sync code 0 (62.5 µs at 48 MHz).
- SYNC_STEP, 500: ticks per code increment (even).
- SWEEP_MAX, 960: pulses strictly shorter are sweeps.
- PAIR_GAP, 48000: sync rise within this many ticks of previous sync rise is station 1.
- SWEEP_WINDOW, 400000: ticks after arming before timeout.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- envelope  in  1  raw, asynchronous photodiode envelope.
- sync_valid  out  1  one-cycle strobe, valid sync decoded.
- sync_code  out  3  {skip, data, axis}; held until next sync_valid.
- sync_station  out  1  0 = first sync of pair, 1 = second; held.
- sweep_valid  out  1  one-cycle strobe, sweep hit measured.
- sweep_time  out  WIDTH  ticks from arming sync rise to sweep pulse centre; held.
- sweep_axis  out  1  axis of arming sync; held.
- sweep_station  out  1  station of arming sync; held.
- timeout  out  1  one-cycle strobe, window expired without sweep.
- error  out  1  one-cycle strobe, pulse width invalid.

## Operation
- envelope passes a 2-flop synchronizer (reset to 0), then a registered edge detector.
- Free-running tick counter t (WIDTH bits, wraps modulo 2^WIDTH). All differences modulo 2^WIDTH.
- Rise: capture t_rise, set seen_rise. Fall with seen_rise=0: ignored, no output. Fall with seen_rise: width = t − t_rise, clear seen_rise, classify.
- Long flag: set if high for more than SYNC_MAX = SYNC_BASE+7·SYNC_STEP+SYNC_STEP/2 ticks; on fall, long flag forces error.
- Classification (exactly one outcome per qualifying fall):
  - width < SWEEP_MAX: sweep.
  - width in [SYNC_BASE+n·STEP−STEP/2, SYNC_BASE+n·STEP+STEP/2), n=0..7: sync, code n. Comparator ladder, no divider.
  - otherwise: error.
- Sync: station = 1 if (t_rise − last_sync_rise) < PAIR_GAP and a previous sync exists since reset, else 0; last_sync_rise ← t_rise. Strobe sync_valid. If skip=0: ref ← t_rise, latch axis/station, state → ARMED (a later non-skip sync re-arms; latest wins).
- Sweep: ARMED → sweep_time = t_rise + (width>>1) − ref, strobe sweep_valid, state → IDLE. IDLE → ignored, no strobe.
- Sync FSM: IDLE, ARMED. ARMED and (t − ref) > SWEEP_WINDOW with no classification this cycle → timeout strobe, IDLE. A classification in the same cycle takes priority; timeout checked next cycle.
- Error does not change FSM state or held outputs.

## Timing
- Reset values: all outputs 0, FSM IDLE, t=0, seen_rise=0, no previous sync.
- Envelope edge to internal edge strobe: 3 clk; both edges equally delayed, so width equals synchronized high-cycle count.
- Strobe outputs assert 1 clk after internal fall strobe (4 clk after envelope fall is sampled); held outputs update in that same cycle.
- Strobes are single-cycle; at most one of sync_valid/sweep_valid/error per cycle; timeout never coincides with them.
- Minimum resolvable low/high time: 2 clk; shorter glitches may be lost.
- Reset mid-pulse: in-progress pulse discarded; if envelope is high at release, that pulse produces nothing.

## Test plan
- Sync high 3000 ticks (code 0), sweep rise 100000 ticks after sync rise, high 200 → sync_valid code 000 station 0; sweep_valid sweep_time=100100, axis 0, station 0.
- Sync high 5000 (code 100, skip), second sync rise 19200 later high 3500 (code 001), sweep rise 150000 after second rise high 100 → two sync_valid (station 0, then 1); sweep_time=150050, axis 1, station 1.
- Boundaries: widths 2750 → code 0; 3250 → code 1; 959 → sweep; 960 → error; 2000 → error; 7000 → error; FSM state unchanged after each error.
- Sync code 000 then no pulse for 400001 ticks → single timeout strobe; a sweep after that → no sweep_valid.
- Assert reset with envelope high, release, drop envelope → no strobes; reset while ARMED → all outputs 0 and subsequent sweep ignored.
- Tick counter wrap: arm at t_rise = 2^20−1000, sweep 3000 ticks later high 200 → sweep_time=3100.
